// File: rtl/cpu_fpu_fma_issue.sv
// Issue stage in front of the fused multiply-add unit: folds the R4 FMA variant into
// operand sign flips and runs the unit's level handshake. Optional: CPU_FPU_FMA_CANON_NAN_EN.
module cpu_fpu_fma_issue #(
    parameter int RD_WIDTH = 5
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [1:0]          i_op,
    input  logic [31:0]         i_rs1,
    input  logic [31:0]         i_rs2,
    input  logic [31:0]         i_rs3,
    input  logic [RD_WIDTH-1:0] i_rd,
    input  logic                i_flush,
    output logic                o_busy,
    output logic                o_valid,
    output logic [RD_WIDTH-1:0] o_rd,
    output logic [31:0]         o_result,
    output logic                o_fma_request,
    output logic [31:0]         o_fma_op1,
    output logic [31:0]         o_fma_op2,
    output logic [31:0]         o_fma_op3,
    input  logic                i_fma_ready,
    input  logic [31:0]         i_fma_result
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_READY   = 2'd1,
        ST_WAIT_RELEASE = 2'd2,
        ST_RESULT       = 2'd3
    } state_t;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // The unit only computes op1*op2+op3, so negation is a plain sign-bit flip.
    function automatic logic [31:0] flip_sign(input logic [31:0] value, input logic en);
        return {value[31] ^ en, value[30:0]};
    endfunction

    function automatic logic [31:0] capture_result(input logic [31:0] raw);
`ifdef CPU_FPU_FMA_CANON_NAN_EN
        if ((raw[30:23] == 8'hFF) && (raw[22:0] != 23'd0)) begin
            return CANON_NAN;
        end else begin
            return raw;
        end
`else
        return raw;
`endif
    endfunction

    state_t                state_r;
    logic                  drop_r;
    logic                  busy_r;
    logic                  strobe_r;
    logic                  request_r;
    logic [RD_WIDTH-1:0]   rd_r;
    logic [31:0]           result_r;
    logic [31:0]           op1_r;
    logic [31:0]           op2_r;
    logic [31:0]           op3_r;

    // A late flush must still be able to swallow the strobe in the result cycle itself.
    assign o_valid       = strobe_r & ~i_flush;
    assign o_busy        = busy_r;
    assign o_rd          = rd_r;
    assign o_result      = result_r;
    assign o_fma_request = request_r;
    assign o_fma_op1     = op1_r;
    assign o_fma_op2     = op2_r;
    assign o_fma_op3     = op3_r;

    // Sequencer: accept, hold request until ready, wait for release, strobe result.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            drop_r    <= 1'b0;
            busy_r    <= 1'b0;
            strobe_r  <= 1'b0;
            request_r <= 1'b0;
            rd_r      <= {RD_WIDTH{1'b0}};
            result_r  <= 32'd0;
            op1_r     <= 32'd0;
            op2_r     <= 32'd0;
            op3_r     <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    strobe_r <= 1'b0;
                    // A still-high ready would be a stale result; never fire into it.
                    if (i_valid && !i_flush && !i_fma_ready) begin
                        op1_r     <= flip_sign(i_rs1, i_op[1]);
                        op2_r     <= i_rs2;
                        op3_r     <= flip_sign(i_rs3, i_op[0]);
                        rd_r      <= i_rd;
                        request_r <= 1'b1;
                        busy_r    <= 1'b1;
                        drop_r    <= 1'b0;
                        state_r   <= ST_WAIT_READY;
                    end
                end
                ST_WAIT_READY: begin
                    if (i_flush) begin
                        drop_r <= 1'b1;
                    end
                    if (i_fma_ready) begin
                        result_r  <= capture_result(i_fma_result);
                        request_r <= 1'b0;
                        state_r   <= ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (!i_fma_ready) begin
                        busy_r <= 1'b0;
                        drop_r <= 1'b0;
                        if (drop_r || i_flush) begin
                            state_r <= ST_IDLE;
                        end else begin
                            strobe_r <= 1'b1;
                            state_r  <= ST_RESULT;
                        end
                    end else if (i_flush) begin
                        drop_r <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    strobe_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    strobe_r  <= 1'b0;
                    request_r <= 1'b0;
                    busy_r    <= 1'b0;
                    drop_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fpu_fma_issue.sv
// Self-checking bench for cpu_fpu_fma_issue: directed table, flush/reset/back-to-back
// sequences and randomized ops against a stub FMA unit and a spec-level model.
module tb_cpu_fpu_fma_issue;
    localparam int RDW = 5;
    localparam logic [31:0] SIGN = 32'h8000_0000;

    logic            clk;
    logic            i_reset;
    logic            i_valid;
    logic [1:0]      i_op;
    logic [31:0]     i_rs1, i_rs2, i_rs3;
    logic [RDW-1:0]  i_rd;
    logic            i_flush;
    logic            o_busy, o_valid, o_fma_request;
    logic [RDW-1:0]  o_rd;
    logic [31:0]     o_result, o_fma_op1, o_fma_op2, o_fma_op3;
    logic            fma_ready;
    logic [31:0]     fma_result;

    cpu_fpu_fma_issue #(.RD_WIDTH(RDW)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .i_op(i_op),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rs3(i_rs3), .i_rd(i_rd), .i_flush(i_flush),
        .o_busy(o_busy), .o_valid(o_valid), .o_rd(o_rd), .o_result(o_result),
        .o_fma_request(o_fma_request), .o_fma_op1(o_fma_op1), .o_fma_op2(o_fma_op2),
        .o_fma_op3(o_fma_op3), .i_fma_ready(fma_ready), .i_fma_result(fma_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cur   = 0;
    logic rise;
    logic smp_valid, smp_busy;
    logic [RDW-1:0] smp_rd;
    logic [31:0] smp_result;
    int ulat = 0;
    bit ulinger = 0;
    bit ulingered = 0;
    int ucnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cur);
        end
    endtask

    // Stand-in for the FMA unit: exact values for the known test operands, a hash otherwise.
    function automatic logic [31:0] unit_fn(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        int v;
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 32'hFFC0_0000;
        if (y == 32'h4040_0000 && (x & ~SIGN) == 32'h4000_0000 && (z & ~SIGN) == 32'h3F80_0000) begin
            v = (x[31] ? -6 : 6) + (z[31] ? -1 : 1);
            case (v)
                7:       return 32'h40E0_0000;
                5:       return 32'h40A0_0000;
                -5:      return 32'hC0A0_0000;
                default: return 32'hC0E0_0000;
            endcase
        end
        return (x ^ {y[15:0], y[31:16]}) + z;
    endfunction

    function automatic logic [31:0] canon(input logic [31:0] r);
`ifdef CPU_FPU_FMA_CANON_NAN_EN
        if (r[30:23] == 8'hFF && r[22:0] != 23'd0) return 32'h7FC0_0000;
`endif
        return r;
    endfunction

    // One clock: sample outputs mid-cycle, advance, then let the unit stub react.
    task automatic tick();
        logic req_before, rdy_before;
        #1;
        cur = cyc;
        smp_valid = o_valid; smp_busy = o_busy; smp_rd = o_rd; smp_result = o_result;
        req_before = o_fma_request; rdy_before = fma_ready;
        @(posedge clk);
        #1;
        cyc++;
        rise = o_fma_request && !req_before;
        if (rise) chk("no_stale_fire", {31'd0, rdy_before}, 32'd0);
        if (i_reset) begin
            fma_ready = 1'b0; ucnt = 0; ulingered = 0;
        end else if (o_fma_request) begin
            if (!fma_ready) begin
                if (ucnt >= ulat) begin
                    fma_ready = 1'b1;
                    fma_result = unit_fn(o_fma_op1, o_fma_op2, o_fma_op3);
                end else ucnt++;
            end
        end else begin
            ucnt = 0;
            if (fma_ready && ulinger && !ulingered) ulingered = 1;
            else begin fma_ready = 1'b0; ulingered = 0; end
        end
    endtask

    // Issue one op and follow it to its strobe (or, if flushed, to the drop of busy).
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic [RDW-1:0] rd,
                          input int d, input bit lg, input int flush_at,
                          input bit use_fixed, input logic [31:0] fixed);
        logic [31:0] e1, e3, want;
        int acc, got;
        bit done, saw_ready;
        e1 = op[1] ? (a ^ SIGN) : a;
        e3 = op[0] ? (c ^ SIGN) : c;
        want = use_fixed ? fixed : canon(unit_fn(e1, b, e3));
        ulat = d; ulinger = lg;
        i_op = op; i_rs1 = a; i_rs2 = b; i_rs3 = c; i_rd = rd; i_valid = 1'b1;
        acc = -1; got = 0; done = 0; saw_ready = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            i_flush = (acc >= 0 && flush_at >= 0 && cyc == acc + flush_at);
            tick();
            if (fma_ready) saw_ready = 1;
            if (rise && acc < 0) begin
                acc = cur;
                i_valid = 1'b0;
                chk({tag, "_op1"}, o_fma_op1, e1);
                chk({tag, "_op2"}, o_fma_op2, b);
                chk({tag, "_op3"}, o_fma_op3, e3);
            end
            if (o_fma_request && !o_busy) chk({tag, "_busy_with_req"}, {31'd0, o_busy}, 32'd1);
            if (smp_valid) begin
                got++;
                if (flush_at >= 0) chk({tag, "_dropped_valid"}, 32'd1, 32'd0);
                else begin
                    chk({tag, "_latency"}, cur - acc, d + 3 + (lg ? 1 : 0));
                    chk({tag, "_rd"}, {27'd0, smp_rd}, {27'd0, rd});
                    chk({tag, "_result"}, smp_result, want);
                    done = 1;
                end
            end
            if (flush_at >= 0 && acc >= 0 && cur > acc && !smp_busy) done = 1;
        end
        i_flush = 1'b0; i_valid = 1'b0;
        if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
        if (flush_at >= 0) begin
            chk({tag, "_flush_handshake"}, {31'd0, saw_ready}, 32'd1);
            chk({tag, "_flush_no_valid"}, got, 32'd0);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, c;
        logic [RDW-1:0] rd;
        int          d;
        bit          lg;
        logic [31:0] res;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int valids, rises, prev_rise;
        i_reset = 1'b1; i_valid = 1'b0; i_op = 2'd0; i_rs1 = 32'd0; i_rs2 = 32'd0;
        i_rs3 = 32'd0; i_rd = '0; i_flush = 1'b0; fma_ready = 1'b0; fma_result = 32'd0;

        tbl[0] = '{2'b00, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd7,  2, 0, 32'h40E0_0000};
        tbl[1] = '{2'b01, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd8,  0, 0, 32'h40A0_0000};
        tbl[2] = '{2'b10, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd9,  3, 1, 32'hC0A0_0000};
        tbl[3] = '{2'b11, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd31, 1, 0, 32'hC0E0_0000};
`ifdef CPU_FPU_FMA_CANON_NAN_EN
        tbl[4] = '{2'b00, 32'h7FC0_0000, 32'h4040_0000, 32'h3F80_0000, 5'd1, 1, 0, 32'h7FC0_0000};
`else
        tbl[4] = '{2'b00, 32'h7FC0_0000, 32'h4040_0000, 32'h3F80_0000, 5'd1, 1, 0, 32'hFFC0_0000};
`endif
        tbl[5] = '{2'b00, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd0, 0, 1, 32'h40E0_0000};

        tick(); tick();
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_req", {31'd0, o_fma_request}, 32'd0);
        chk("rst_rd", {27'd0, o_rd}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_op1", o_fma_op1, 32'd0);
        chk("rst_op2", o_fma_op2, 32'd0);
        chk("rst_op3", o_fma_op3, 32'd0);
        i_reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c,
                   tbl[i].rd, tbl[i].d, tbl[i].lg, -1, 1'b1, tbl[i].res);

        // Flush two cycles after acceptance, then a clean op behind it.
        run_op("flush", 2'b00, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd3, 3, 0, 2, 1'b1, 32'h40E0_0000);
        run_op("after_flush", 2'b00, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd4, 1, 0, -1, 1'b1, 32'h40E0_0000);

        // Valid and flush together in IDLE: ignored.
        i_valid = 1'b1; i_flush = 1'b1; ulat = 1; ulinger = 0;
        tick(); tick();
        chk("valid_with_flush", {31'd0, o_fma_request}, 32'd0);
        i_valid = 1'b0; i_flush = 1'b0;

        // Back-to-back with i_valid held high.
        ulat = 1; ulinger = 0; valids = 0; rises = 0; prev_rise = -1;
        i_op = 2'b00; i_rs1 = 32'h4000_0000; i_rs2 = 32'h4040_0000; i_rs3 = 32'h3F80_0000;
        i_rd = 5'd12; i_valid = 1'b1;
        for (int n = 0; n < 80 && (valids < 4 || o_busy); n++) begin
            tick();
            if (rise) begin
                rises++;
                if (prev_rise >= 0) chk("b2b_spacing", cur - prev_rise, 32'd5);
                prev_rise = cur;
            end
            if (smp_valid) begin
                valids++;
                chk("b2b_result", smp_result, 32'h40E0_0000);
                if (valids >= 4) i_valid = 1'b0;
            end
        end
        i_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (smp_valid) valids++;
            if (rise) rises++;
        end
        chk("b2b_valids", valids, 32'd4);
        chk("b2b_one_valid_per_op", valids, rises);

        // Reset while waiting for ready.
        ulat = 6; ulinger = 0;
        i_op = 2'b00; i_rs1 = 32'h4000_0000; i_rd = 5'd5; i_valid = 1'b1;
        tick(); i_valid = 1'b0; tick(); tick();
        chk("pre_reset_req", {31'd0, o_fma_request}, 32'd1);
        i_reset = 1'b1;
        tick();
        chk("reset_req", {31'd0, o_fma_request}, 32'd0);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        i_reset = 1'b0;
        valids = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (smp_valid) valids++;
        end
        chk("reset_no_valid", valids, 32'd0);

        // Randomized ops, some flushed mid-flight.
        for (int i = 0; i < 40; i++) begin
            int d, fl;
            d = $urandom_range(0, 5);
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, d + 2) : -1;
            run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                   RDW'($urandom_range(0, 31)), d, 1'($urandom_range(0, 1)), fl, 1'b0, 32'd0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
